// File: rtl/xy2_src_arbiter.sv
// xy2_src_arbiter: N-channel XY2-100 source arbiter with safe-point switching (drain + blanking guard).
// Optional macro XY2_PARK_EN: IDLE drives PARK_X/PARK_Y instead of holding the last coordinates.
module xy2_src_arbiter #(
   parameter int                 NUM_CH    = 4,
   parameter int                 COORD_W   = 16,
   parameter int                 DRAIN_MAX = 64,
   parameter int                 GUARD_CYC = 4,
   parameter logic [COORD_W-1:0] PARK_X    = 16'h8000,
   parameter logic [COORD_W-1:0] PARK_Y    = 16'h8000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic [NUM_CH-1:0]           ch_send,
   input  logic [NUM_CH*COORD_W-1:0]   ch_x,
   input  logic [NUM_CH*COORD_W-1:0]   ch_y,
   output logic                        out_send,
   output logic [COORD_W-1:0]          out_x,
   output logic [COORD_W-1:0]          out_y,
   output logic [$clog2(NUM_CH)-1:0]   active_ch,
   output logic                        active_valid,
   output logic                        busy_switch
);

   localparam int CH_W    = $clog2(NUM_CH);
   localparam int CNT_MAX = (DRAIN_MAX > GUARD_CYC) ? DRAIN_MAX : GUARD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_GUARD  = 2'd3
   } state_t;

   state_t               r_state;
   logic [NUM_CH-1:0]    r_en_q;
   logic [NUM_CH-1:0]    r_pend;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_out_send;
   logic [COORD_W-1:0]   r_out_x;
   logic [COORD_W-1:0]   r_out_y;
   logic [CH_W-1:0]      r_active_ch;
   logic                 r_active_valid;
   logic                 r_busy;

   logic [NUM_CH-1:0]    w_rise;
   logic [NUM_CH-1:0]    w_owner_mask;
   logic [NUM_CH-1:0]    w_pend_nxt;
   logic [NUM_CH-1:0]    w_grant_oh;
   logic [CH_W-1:0]      w_grant;
   logic                 w_sel_send;
   logic [COORD_W-1:0]   w_sel_x;
   logic [COORD_W-1:0]   w_sel_y;
   logic                 w_en_owner;
   logic                 w_drain_done;
   logic                 w_guard_done;
   logic [CNT_W-1:0]     w_cnt_inc;

   assign w_rise       = ch_en & ~r_en_q;
   assign w_sel_send   = ch_send[r_active_ch];
   assign w_sel_x      = ch_x[int'(r_active_ch) * COORD_W +: COORD_W];
   assign w_sel_y      = ch_y[int'(r_active_ch) * COORD_W +: COORD_W];
   assign w_en_owner   = ch_en[r_active_ch];
   assign w_drain_done = ~w_sel_send | (r_cnt == CNT_W'(DRAIN_MAX - 1));
   assign w_guard_done = (r_cnt == CNT_W'(GUARD_CYC - 1));
   assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

   // A re-rise from the channel that still owns the path must not queue it again
   always_comb begin
      w_owner_mask = '0;
      if (r_state == ST_ACTIVE || r_state == ST_DRAIN) begin
         w_owner_mask[r_active_ch] = 1'b1;
      end else begin
         w_owner_mask = '0;
      end
   end

   // Fixed priority: isolate the lowest set pending bit and encode it
   always_comb begin
      w_grant_oh = r_pend & (~r_pend + NUM_CH'(1));
      w_grant    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_grant = w_grant | (w_grant_oh[i] ? CH_W'(i) : CH_W'(0));
      end
   end

   // Next pending vector: set on rise, dropped as soon as the channel lets go of ch_en
   always_comb begin
      w_pend_nxt = (r_pend | (w_rise & ~w_owner_mask)) & ch_en;
   end

`ifndef XY2_PARK_EN
   logic w_unused_park;
   assign w_unused_park = ^{PARK_X, PARK_Y};
`endif

   // Arbitration FSM with registered pass-through outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_en_q         <= '0;
         r_pend         <= '0;
         r_cnt          <= '0;
         r_out_send     <= 1'b0;
         r_out_x        <= '0;
         r_out_y        <= '0;
         r_active_ch    <= '0;
         r_active_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_en_q <= ch_en;
         r_pend <= w_pend_nxt;
         case (r_state)
            ST_IDLE: begin
               r_out_send <= 1'b0;
`ifdef XY2_PARK_EN
               r_out_x <= PARK_X;
               r_out_y <= PARK_Y;
`endif
               if (|r_pend) begin
                  r_state        <= ST_ACTIVE;
                  r_active_ch    <= w_grant;
                  r_pend         <= w_pend_nxt & ~w_grant_oh;
                  r_active_valid <= 1'b1;
                  r_busy         <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               r_out_send <= w_sel_send;
               r_out_x    <= w_sel_x;
               r_out_y    <= w_sel_y;
               if ((|r_pend) || !w_en_owner) begin
                  r_state <= ST_DRAIN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               r_out_send <= w_sel_send;
               r_out_x    <= w_sel_x;
               r_out_y    <= w_sel_y;
               if (w_drain_done) begin
                  r_cnt <= '0;
                  if (GUARD_CYC == 0) begin
                     r_busy <= 1'b0;
                     if (|r_pend) begin
                        r_state        <= ST_ACTIVE;
                        r_active_ch    <= w_grant;
                        r_pend         <= w_pend_nxt & ~w_grant_oh;
                        r_active_valid <= 1'b1;
                     end else begin
                        r_state        <= ST_IDLE;
                        r_active_valid <= 1'b0;
                     end
                  end else begin
                     r_state        <= ST_GUARD;
                     r_active_valid <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_GUARD: begin
               r_out_send <= 1'b0;
               if (w_guard_done) begin
                  r_cnt  <= '0;
                  r_busy <= 1'b0;
                  if (|r_pend) begin
                     r_state        <= ST_ACTIVE;
                     r_active_ch    <= w_grant;
                     r_pend         <= w_pend_nxt & ~w_grant_oh;
                     r_active_valid <= 1'b1;
                  end else begin
                     r_state        <= ST_IDLE;
                     r_active_valid <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_send     = r_out_send;
   assign out_x        = r_out_x;
   assign out_y        = r_out_y;
   assign active_ch    = r_active_ch;
   assign active_valid = r_active_valid;
   assign busy_switch  = r_busy;

endmodule

// File: tb/tb_xy2_src_arbiter.sv
// Self-checking bench for xy2_src_arbiter: vector table, directed switch sequences, randomized run vs reference model.
module tb_xy2_src_arbiter;

   localparam int NUM_CH    = 4;
   localparam int COORD_W   = 16;
   localparam int DRAIN_MAX = 64;
   localparam int GUARD_CYC = 4;
`ifdef XY2_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif
   localparam logic [15:0] PK = 16'h8000;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ch_en, ch_send;
   logic [63:0] ch_x, ch_y;
   logic [15:0] tx [4];
   logic [15:0] ty [4];
   logic        out_send, active_valid, busy_switch;
   logic [15:0] out_x, out_y;
   logic [1:0]  active_ch;

   int n_checks = 0;
   int n_fail   = 0;

   xy2_src_arbiter #(.NUM_CH(NUM_CH), .COORD_W(COORD_W), .DRAIN_MAX(DRAIN_MAX),
                     .GUARD_CYC(GUARD_CYC), .PARK_X(16'h8000), .PARK_Y(16'h8000)) dut (
      .clk(clk), .reset(reset), .ch_en(ch_en), .ch_send(ch_send), .ch_x(ch_x), .ch_y(ch_y),
      .out_send(out_send), .out_x(out_x), .out_y(out_y), .active_ch(active_ch),
      .active_valid(active_valid), .busy_switch(busy_switch));

   always #5 clk = ~clk;

   always_comb begin
      ch_x = '0;
      ch_y = '0;
      for (int i = 0; i < 4; i++) begin
         ch_x[i*16 +: 16] = tx[i];
         ch_y[i*16 +: 16] = ty[i];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: owner/queue bookkeeping with explicit drain and guard budgets
   logic [3:0]  m_en_q = '0, m_pend = '0;
   int          m_owner = 0, m_dn = 0, m_gl = 0;
   bit          m_owned = 1'b0, m_drain = 1'b0;
   logic        m_send = 1'b0;
   logic [15:0] m_x = '0, m_y = '0;

   function automatic int lowest(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      logic [3:0] np;
      int g;
      bit take;
      if (reset) begin
         m_en_q = '0; m_pend = '0; m_owner = 0; m_dn = 0; m_gl = 0;
         m_owned = 1'b0; m_drain = 1'b0; m_send = 1'b0; m_x = '0; m_y = '0;
         return;
      end
      if (m_owned) begin
         m_send = ch_send[m_owner]; m_x = tx[m_owner]; m_y = ty[m_owner];
      end else begin
         m_send = 1'b0;
         if (PARK && m_gl == 0) begin m_x = PK; m_y = PK; end
      end
      np = m_pend;
      for (int i = 0; i < 4; i++) begin
         if (ch_en[i] && !m_en_q[i] && !(m_owned && m_owner == i)) np[i] = 1'b1;
         if (!ch_en[i]) np[i] = 1'b0;
      end
      g = lowest(m_pend);
      take = 1'b0;
      if (m_gl > 0) begin
         m_gl--;
         if (m_gl == 0) take = 1'b1;
      end else if (!m_owned) begin
         take = 1'b1;
      end else if (!m_drain) begin
         if (m_pend != 4'b0 || !ch_en[m_owner]) begin m_drain = 1'b1; m_dn = 0; end
      end else if (!ch_send[m_owner] || m_dn == DRAIN_MAX - 1) begin
         m_owned = 1'b0; m_drain = 1'b0;
         if (GUARD_CYC > 0) m_gl = GUARD_CYC; else take = 1'b1;
      end else begin
         m_dn++;
      end
      if (take && g >= 0) begin
         m_owner = g; m_owned = 1'b1; m_drain = 1'b0; np[g] = 1'b0;
      end
      m_en_q = ch_en;
      m_pend = np;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic compare_model();
      check("rand_send", 32'(out_send), 32'(m_send));
      check("rand_x", 32'(out_x), 32'(m_x));
      check("rand_y", 32'(out_y), 32'(m_y));
      check("rand_ach", 32'(active_ch), 32'(m_owner));
      check("rand_valid", 32'(active_valid), 32'(m_owned));
      check("rand_busy", 32'(busy_switch), 32'(m_drain || m_gl > 0));
   endtask

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  send;
      logic        e_send;
      logic [15:0] e_x;
      logic [15:0] e_y;
      logic [1:0]  e_ach;
      logic        e_av;
      logic        e_busy;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int d, g, w;
      logic [15:0] ix;
      logic [15:0] iy;
      ix = PARK ? PK : 16'h0000;
      iy = PARK ? PK : 16'h0000;
      tx[0] = 16'hAAAA; ty[0] = 16'h5555;
      tx[1] = 16'h1111; ty[1] = 16'h2222;
      tx[2] = 16'h1234; ty[2] = 16'h5678;
      tx[3] = 16'h3333; ty[3] = 16'h4444;
      // request on ch2, then ch0 queues behind it: drain on send drop, 4 guard cycles, switch
      tbl[0]  = '{4'b0100, 4'b0000, 1'b0, ix,       iy,       2'd0, 1'b0, 1'b0};
      tbl[1]  = '{4'b0100, 4'b0100, 1'b0, ix,       iy,       2'd2, 1'b1, 1'b0};
      tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 16'h1234, 16'h5678, 2'd2, 1'b1, 1'b0};
      tbl[3]  = '{4'b0101, 4'b0100, 1'b1, 16'h1234, 16'h5678, 2'd2, 1'b1, 1'b0};
      tbl[4]  = '{4'b0101, 4'b0100, 1'b1, 16'h1234, 16'h5678, 2'd2, 1'b1, 1'b1};
      tbl[5]  = '{4'b0101, 4'b0000, 1'b0, 16'h1234, 16'h5678, 2'd2, 1'b0, 1'b1};
      tbl[6]  = '{4'b0101, 4'b0000, 1'b0, 16'h1234, 16'h5678, 2'd2, 1'b0, 1'b1};
      tbl[7]  = '{4'b0101, 4'b0000, 1'b0, 16'h1234, 16'h5678, 2'd2, 1'b0, 1'b1};
      tbl[8]  = '{4'b0101, 4'b0000, 1'b0, 16'h1234, 16'h5678, 2'd2, 1'b0, 1'b1};
      tbl[9]  = '{4'b0101, 4'b0000, 1'b0, 16'h1234, 16'h5678, 2'd0, 1'b1, 1'b0};
      tbl[10] = '{4'b0101, 4'b0001, 1'b1, 16'hAAAA, 16'h5555, 2'd0, 1'b1, 1'b0};

      reset = 1'b1; ch_en = '0; ch_send = '0;
      repeat (3) tick();
      check("reset_out", {out_send, out_x, out_y, active_ch, active_valid, busy_switch}, 32'd0);
      reset = 1'b0;

      for (int r = 0; r < 11; r++) begin
         ch_en = tbl[r].en; ch_send = tbl[r].send;
         tick();
         check($sformatf("vec%0d_send", r), 32'(out_send), 32'(tbl[r].e_send));
         check($sformatf("vec%0d_x", r), 32'(out_x), 32'(tbl[r].e_x));
         check($sformatf("vec%0d_y", r), 32'(out_y), 32'(tbl[r].e_y));
         check($sformatf("vec%0d_ach", r), 32'(active_ch), 32'(tbl[r].e_ach));
         check($sformatf("vec%0d_valid", r), 32'(active_valid), 32'(tbl[r].e_av));
         check($sformatf("vec%0d_busy", r), 32'(busy_switch), 32'(tbl[r].e_busy));
      end

      // ch0 active sending, ch1 requests, send held 10 drain cycles
      ch_en = 4'b0111;
      w = 0;
      while (!busy_switch && w < 10) begin tick(); w++; end
      d = (busy_switch && active_valid) ? 1 : 0;
      repeat (9) begin tick(); if (busy_switch && active_valid) d++; end
      ch_send = 4'b0000;
      tick();
      g = 0;
      while (!active_valid && g < 20) begin
         g++;
         check("guard_send", 32'(out_send), 32'd0);
         check("guard_hold_x", 32'(out_x), 32'hAAAA);
         tick();
      end
      check("drain10_cycles", d, 10);
      check("guard_cycles", g, 4);
      check("switch_to_ch1", 32'(active_ch), 32'd1);

      // ch1 send stuck high: forced exit after DRAIN_MAX cycles
      ch_en = 4'b0010; ch_send = 4'b0010;
      repeat (3) tick();
      check("ch1_fwd_x", 32'(out_x), 32'h1111);
      check("ch1_fwd_send", 32'(out_send), 32'd1);
      ch_en = 4'b1010;
      w = 0;
      while (!busy_switch && w < 10) begin tick(); w++; end
      d = 0;
      while (busy_switch && active_valid && d < 200) begin d++; tick(); end
      g = 0;
      while (busy_switch && !active_valid && g < 20) begin
         g++;
         check("fguard_hold_x", 32'(out_x), 32'h1111);
         tick();
      end
      check("forced_drain_cycles", d, DRAIN_MAX);
      check("forced_guard_cycles", g, GUARD_CYC);
      check("switch_to_ch3", 32'(active_ch), 32'd3);

      // back to IDLE, then simultaneous rises on ch3 and ch1
      ch_en = 4'b0000; ch_send = 4'b0000;
      w = 0;
      while ((active_valid || busy_switch) && w < 40) begin tick(); w++; end
      tick();
      check("idle_valid", 32'(active_valid), 32'd0);
      check("idle_hold_x", 32'(out_x), PARK ? 32'(PK) : 32'h3333);
      ch_en = 4'b1010; ch_send = 4'b0010;
      tick(); tick();
      check("simul_first_ch1", 32'(active_ch), 32'd1);
      check("simul_first_valid", 32'(active_valid), 32'd1);
      ch_en = 4'b1000; ch_send = 4'b0000;
      w = 0;
      while (!(active_valid && !busy_switch && active_ch == 2'd3) && w < 40) begin tick(); w++; end
      check("simul_then_ch3", 32'(active_ch), 32'd3);
      repeat (5) tick();
      check("pend_empty_no_drain", 32'(busy_switch), 32'd0);

      // ch0 active, ch2 pulse aborted during drain -> IDLE
      ch_en = 4'b0000;
      w = 0;
      while ((active_valid || busy_switch) && w < 40) begin tick(); w++; end
      ch_en = 4'b0001; ch_send = 4'b0001;
      tick(); tick(); tick();
      check("ch0_active", {30'd0, active_ch}, 32'd0);
      check("ch0_fwd_x", 32'(out_x), 32'hAAAA);
      ch_en = 4'b0101;
      tick(); tick();
      ch_en = 4'b0001;
      repeat (3) tick();
      check("abort_in_drain", 32'({busy_switch, active_valid}), 32'd3);
      ch_send = 4'b0000;
      w = 0;
      while (busy_switch && w < 40) begin tick(); w++; end
      tick();
      check("abort_to_idle_valid", 32'(active_valid), 32'd0);
      check("abort_to_idle_busy", 32'(busy_switch), 32'd0);
      check("abort_hold_x", 32'(out_x), PARK ? 32'(PK) : 32'hAAAA);
      check("abort_hold_y", 32'(out_y), PARK ? 32'(PK) : 32'h5555);

      // reset during drain, then a fresh request
      ch_en = 4'b0011; ch_send = 4'b0010;
      tick(); tick();
      ch_en = 4'b0111;
      tick(); tick();
      check("pre_reset_drain", 32'({busy_switch, active_valid}), 32'd3);
      reset = 1'b1; ch_en = 4'b0000; ch_send = 4'b0000;
      tick();
      check("mid_reset_out", {out_send, out_x, out_y, active_ch, active_valid, busy_switch}, 32'd0);
      reset = 1'b0;
      tick();
      ch_en = 4'b1000; ch_send = 4'b1000;
      tick(); tick();
      check("post_reset_grant", 32'({active_valid, active_ch}), 32'h7);
      tick();
      check("post_reset_fwd_x", 32'(out_x), 32'h3333);
      check("post_reset_fwd_send", 32'(out_send), 32'd1);

      // randomized run against the reference model
      reset = 1'b1; ch_en = '0; ch_send = '0;
      tick(); tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 11) == 0) ch_en[i] = ~ch_en[i];
            ch_send[i] = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
               tx[i] = 16'($urandom);
               ty[i] = 16'($urandom);
            end
         end
         reset = ($urandom_range(0, 699) == 0);
         tick();
         compare_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
